// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between upstream logic and the UART transmitter FIFO.
// The upstream side is the master: it drives data and valid, and
// the FIFO answers with ready.
interface uart_tx_fifo_if;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;

   modport master (
      output tx_data_i,
      output tx_valid_i,
      input  tx_ready_o
   );

   modport slave (
      input  tx_data_i,
      input  tx_valid_i,
      output tx_ready_o
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular-buffer FIFO.
// Bytes are accepted through a valid/ready handshake and sent LSB-first:
// one start bit, eight data bits and one stop bit, each CLK_PER_BIT cycles long.
// All outputs are registered. They are computed from the next-state values,
// so each output lines up with the state it belongs to.
module uart_tx_fifo #(
   parameter int CLK_PER_BIT = 10417,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic          clk,
   input  logic          rst_n_i,
   uart_tx_fifo_if.slave tx_if,
   output logic          tx_o,
   output logic          tx_busy_o,
   output logic          tx_done_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0]      LAST_CYCLE = 32'(CLK_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [7:0]       shift;
   logic [7:0]       shift_next;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_next;
   logic [31:0]      cycle_cnt;
   logic [31:0]      cycle_cnt_next;
   logic             push;
   logic             pop;
   logic             bit_end;
   logic             tx_next;
   logic             done_next;

   assign push    = tx_if.tx_valid_i && tx_if.tx_ready_o;
   assign pop     = (state == IDLE) && (count != '0);
   assign bit_end = (cycle_cnt == LAST_CYCLE);

   // Occupancy bookkeeping: a simultaneous push and pop cancel out
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // Byte storage is written only on an accepted push; it needs no reset because count guards every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= tx_if.tx_data_i;
      end
   end

   // FIFO pointers and occupancy; ready comes from the next count, so a pop from full shows up one cycle later
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         tx_if.tx_ready_o <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count            <= count_next;
         tx_if.tx_ready_o <= (count_next != FULL_COUNT);
      end
   end

   // State register, together with the shift register and the bit and cycle counters that travel with it
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         shift     <= '0;
         bit_idx   <= '0;
         cycle_cnt <= '0;
      end else begin
         state     <= state_next;
         shift     <= shift_next;
         bit_idx   <= bit_idx_next;
         cycle_cnt <= cycle_cnt_next;
      end
   end

   // Next-state logic: every non-idle state holds for CLK_PER_BIT cycles, and IDLE pops as soon as a byte is waiting
   always_comb begin
      state_next     = state;
      shift_next     = shift;
      bit_idx_next   = bit_idx;
      cycle_cnt_next = cycle_cnt;
      case (state)
         IDLE: begin
            if (pop) begin
               state_next     = START;
               shift_next     = fifo_mem[rd_ptr];
               bit_idx_next   = '0;
               cycle_cnt_next = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_next     = DATA;
               bit_idx_next   = '0;
               cycle_cnt_next = '0;
            end else begin
               cycle_cnt_next = cycle_cnt + 32'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_next     = {1'b0, shift[7:1]};
               bit_idx_next   = bit_idx + 3'd1;
               cycle_cnt_next = '0;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end
            end else begin
               cycle_cnt_next = cycle_cnt + 32'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_next     = IDLE;
               cycle_cnt_next = '0;
            end else begin
               cycle_cnt_next = cycle_cnt + 32'd1;
            end
         end
         default: begin
            state_next     = IDLE;
            bit_idx_next   = '0;
            cycle_cnt_next = '0;
         end
      endcase
   end

   // Output decode from the upcoming state, so the registered line level matches that state's cycle
   always_comb begin
      tx_next   = 1'b1;
      done_next = 1'b0;
      case (state_next)
         START: tx_next = 1'b0;
         DATA:  tx_next = shift_next[0];
         STOP: begin
            tx_next   = 1'b1;
            done_next = (cycle_cnt_next == LAST_CYCLE);
         end
         default: tx_next = 1'b1;
      endcase
   end

   // Output registers: the line idles high and busy covers both queued bytes and a frame in flight
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         tx_o      <= 1'b1;
         tx_busy_o <= 1'b0;
         tx_done_o <= 1'b0;
      end else begin
         tx_o      <= tx_next;
         tx_busy_o <= (state_next != IDLE) || (count_next != '0);
         tx_done_o <= done_next;
      end
   end

endmodule
